word_uart_tx: RTL and testbench

- Serial transmitter that takes one DATA_W-bit word over a valid/ready handshake.
- Sends the word as DATA_W/8 back-to-back UART frames: 8N1, least-significant byte first, each byte LSB first.
- Transmit-side counterpart of the board's serial word receiver; streams 32-bit register and memory contents off-chip to a host.
- Sits between the processor's memory-mapped I/O write path and the TX pin.

---
 rtl/word_uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/word_uart_tx.sv | 142 ++++++++++++++
 tb/tb_word_uart_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/word_uart_pkg.sv
// Shared types and constants for the word UART transmitter and its baud timer.
// FRAME_BITS follows WORD_UART_TX_PARITY_EN (11 with the parity bit, 10 for plain 8N1).
package word_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int BITS_PER_BYTE = 8;

`ifdef WORD_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last count.
// restart_i holds the count at zero, so the first tick lands CLKS_PER_BIT cycles after it drops.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = !restart_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/word_uart_tx.sv
// Word-wide UART transmitter: one DATA_W word per handshake, sent LSB byte first as 8N1 frames.
// Define WORD_UART_TX_PARITY_EN to insert an even-parity bit after the data bits of every frame.
module word_uart_tx
  import word_uart_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int                 NUM_BYTES = DATA_W / BITS_PER_BYTE;
  localparam int                 BYTE_CW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_CW-1:0] LAST_BYTE = BYTE_CW'(NUM_BYTES - 1);
  localparam logic [2:0]         LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  uart_state_e        state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [2:0]         bitCnt_q;
  logic [BYTE_CW-1:0] byteCnt_q;
  logic               tx_q;
  logic               inReady_q;
  logic               busy_q;
  logic               done_q;
  logic               baudTick;
  logic               baudRestart;
`ifdef WORD_UART_TX_PARITY_EN
  logic               parity_q;
`endif

  // The timer idles at zero so every start bit gets a full CLKS_PER_BIT period.
  assign baudRestart = (state_q == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .clr_n    (clr_n),
    .restart_i(baudRestart),
    .tick_o   (baudTick)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      tx_q      <= 1'b1;
      inReady_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WORD_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && inReady_q) begin
            shift_q   <= in_data;
            byteCnt_q <= '0;
            bitCnt_q  <= '0;
            tx_q      <= 1'b0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (baudTick) begin
            state_q  <= DATA;
            bitCnt_q <= '0;
            tx_q     <= shift_q[0];
`ifdef WORD_UART_TX_PARITY_EN
            parity_q <= ^shift_q[BITS_PER_BYTE-1:0];
`endif
          end
        end
        DATA: begin
          if (baudTick) begin
            // The final shift of a byte leaves the next byte's LSB in shift_q[0].
            shift_q <= shift_q >> 1;
            if (bitCnt_q == LAST_BIT) begin
`ifdef WORD_UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bitCnt_q <= bitCnt_q + 3'd1;
              tx_q     <= shift_q[1];
            end
          end
        end
`ifdef WORD_UART_TX_PARITY_EN
        PARITY: begin
          if (baudTick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baudTick) begin
            if (byteCnt_q == LAST_BYTE) begin
              state_q   <= IDLE;
              done_q    <= 1'b1;
              inReady_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              byteCnt_q <= byteCnt_q + 1'b1;
              state_q   <= START;
              tx_q      <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          tx_q      <= 1'b1;
          inReady_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = inReady_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx (DATA_W=32, CLKS_PER_BIT=4): vector table, random words, reset corner cases.
// Expected line activity comes from the frame rules; WORD_UART_TX_PARITY_EN also enables parity checks.
module tb_word_uart_tx;
  import word_uart_pkg::*;

  localparam int C     = 4;
  localparam int NB    = 4;
  localparam int TOTAL = NB * FRAME_BITS * C;

  logic        clk;
  logic        clr_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] expBytes;
    logic [3:0]  expPar;
    bit          ignoreIn;
    bit          chain;
  } vec_t;

  vec_t vecs[5];

  word_uart_tx #(
    .DATA_W      (32),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level t cycles after the accept edge, straight from the frame layout.
  function automatic logic expTx(input logic [31:0] w, input int t);
    int bitIdx  = t / C;
    int byteIdx = bitIdx / FRAME_BITS;
    int pos     = bitIdx % FRAME_BITS;
    logic [7:0] b = w[byteIdx*8 +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && FRAME_BITS == 11) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [3:0] parOf(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^w[i*8 +: 8];
    return p;
  endfunction

  // Caller is at a falling edge; returns at the falling edge after done (or in the done cycle when chaining).
  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] expBytes,
                               input logic [3:0] expPar, input bit ignoreIn, input bit chain);
    int waits = 0;
    int waveErr = 0;
    int flagErr = 0;
    logic [31:0] dec = '0;
    logic [3:0] decPar = '0;
    in_data  = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("acceptWait", 32'(waits < 100), 32'd1);
    if (waits >= 100) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!chain) in_valid = 1'b0;
    for (int t = 0; t < TOTAL; t++) begin
      if (tx !== expTx(w, t)) waveErr++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) flagErr++;
      if (t % C == C / 2) begin
        int bitIdx  = t / C;
        int byteIdx = bitIdx / FRAME_BITS;
        int pos     = bitIdx % FRAME_BITS;
        if (pos >= 1 && pos <= 8) dec[byteIdx*8 + pos - 1] = tx;
        if (pos == 9 && FRAME_BITS == 11) decPar[byteIdx] = tx;
      end
      if (ignoreIn) begin
        in_data  = $urandom;
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    checkOutput("waveform", 32'(waveErr), 32'd0);
    checkOutput("busyFlags", 32'(flagErr), 32'd0);
    checkOutput("decode", dec, expBytes);
`ifdef WORD_UART_TX_PARITY_EN
    checkOutput("parity", {28'd0, decPar}, {28'd0, expPar});
`endif
    checkOutput("doneCycle", {28'd0, done, tx, in_ready, busy}, 32'b1110);
    in_valid = chain;
    if (!chain) begin
      @(negedge clk);
      checkOutput("doneOnce", {28'd0, done, tx, in_ready, busy}, 32'b0110);
    end
  endtask

  initial begin
    int idleErr;
    logic [31:0] w;
    in_data  = '0;
    in_valid = 1'b0;
    clr_n    = 1'b1;
    #1 clr_n = 1'b0;

    vecs[0] = '{32'hA5C3_0F81, {8'hA5, 8'hC3, 8'h0F, 8'h81}, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0001, {8'h00, 8'h00, 8'h00, 8'h01}, 4'b0001, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b0000, 1'b0, 1'b0};
    vecs[3] = '{32'h1234_5678, {8'h12, 8'h34, 8'h56, 8'h78}, 4'b0100, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0301, {8'h00, 8'h00, 8'h03, 8'h01}, 4'b0001, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("inReset", {28'd0, done, tx, in_ready, busy}, 32'b0110);
    clr_n = 1'b1;
    idleErr = 0;
    repeat (20) begin
      @(negedge clk);
      if ({done, tx, in_ready, busy} !== 4'b0110) idleErr++;
    end
    checkOutput("idleAfterReset", 32'(idleErr), 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].word, vecs[i].expBytes, vecs[i].expPar, vecs[i].ignoreIn, vecs[i].chain);
    end

    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      applyStimulus(w, w, parOf(w), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset lands on bit 0 of byte 2 (a low bit of 0x22), between clock edges.
    in_data  = 32'h1122_3344;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2 * FRAME_BITS * C + C + 1) @(negedge clk);
    checkOutput("preResetLow", {31'd0, tx}, 32'd0);
    #1 clr_n = 1'b0;
    #1 checkOutput("asyncReset", {28'd0, done, tx, in_ready, busy}, 32'b0110);
    @(negedge clk);
    checkOutput("heldReset", {28'd0, done, tx, in_ready, busy}, 32'b0110);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    applyStimulus(32'hDEAD_BEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, parOf(32'hDEAD_BEEF), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
